// File: rtl/alu_pipe.sv
// alu_pipe: pipelined integer ALU / branch-resolution unit.
// An accepted op is evaluated combinationally, then carried through STAGES
// register stages with per-stage valid/ready so bubbles collapse under stall.
// The last stage presents the result, branch resolution and mispredict flag.
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,   // legal 1..4, equals latency in cycles
    parameter int ROB_W  = 5,
    parameter int PHYS_W = 6,
    parameter int ARCH_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic [XLEN-1:0]   op_imm,
    input  logic              use_imm,
    input  logic [3:0]        alu_op,
    input  logic [1:0]        ctrl_type,
    input  logic [2:0]        funct3,
    input  logic [31:0]       pc,
    input  logic              pred_taken,
    input  logic [31:0]       pred_target,
    input  logic [ARCH_W-1:0] rd_arch,
    input  logic [PHYS_W-1:0] pd_phys,
    input  logic [ROB_W-1:0]  rob_idx,
    input  logic              dest_we,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_value,
    output logic [ARCH_W-1:0] resp_rd,
    output logic [PHYS_W-1:0] resp_pd,
    output logic [ROB_W-1:0]  resp_rob_idx,
    output logic              resp_dest_we,
    output logic              resp_is_ctrl,
    output logic              resp_br_taken,
    output logic [31:0]       resp_br_target,
    output logic              resp_mispredict,
    output logic [2:0]        inflight
);

    localparam int SH_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR  = 4'd3,
        OP_AND  = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
        OP_SLT  = 4'd8, OP_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        CTRL_NONE = 2'd0, CTRL_BRANCH = 2'd1, CTRL_JAL = 2'd2, CTRL_JALR = 2'd3
    } ctrl_e;

    typedef struct packed {
        logic [XLEN-1:0]   value;
        logic [ARCH_W-1:0] rd;
        logic [PHYS_W-1:0] pd;
        logic [ROB_W-1:0]  rob;
        logic              dest_we;
        logic              is_ctrl;
        logic              taken;
        logic [31:0]       target;
        logic              mispredict;
    } stage_t;

    logic [XLEN-1:0]   w_b;
    logic [SH_W-1:0]   w_shamt;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_cond;
    logic [31:0]       w_pc4;
    logic [31:0]       w_pc_imm;
    logic [XLEN-1:0]   w_jalr_sum;
    stage_t            w_stage0;
    logic [STAGES:0]   w_stage_ready;

    logic [STAGES-1:0] r_valid;
    stage_t            r_stage [STAGES];

    assign w_b        = use_imm ? op_imm : op_b;
    assign w_shamt    = w_b[SH_W-1:0];
    assign w_pc4      = pc + 32'd4;
    assign w_pc_imm   = pc + 32'(op_imm);
    assign w_jalr_sum = op_a + op_imm;

    // ALU datapath: select the arithmetic/logic result for alu_op.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_alu_res = '0;
        case (alu_op)
            OP_ADD:  w_alu_res = op_a + w_b;
            OP_SUB:  w_alu_res = op_a - w_b;
            OP_XOR:  w_alu_res = op_a ^ w_b;
            OP_OR:   w_alu_res = op_a | w_b;
            OP_AND:  w_alu_res = op_a & w_b;
            OP_SLL:  w_alu_res = op_a << w_shamt;
            OP_SRL:  w_alu_res = op_a >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(op_a) >>> w_shamt);
            OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(w_b))};
            OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < w_b)};
            default: w_alu_res = '0;
        endcase
    end

    // Branch condition from funct3; compares always use op_a against op_b.
    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:  w_cond = (op_a == op_b);
            3'b001:  w_cond = (op_a != op_b);
            3'b100:  w_cond = ($signed(op_a) <  $signed(op_b));
            3'b101:  w_cond = ($signed(op_a) >= $signed(op_b));
            3'b110:  w_cond = (op_a <  op_b);
            3'b111:  w_cond = (op_a >= op_b);
            default: w_cond = 1'b0;
        endcase
    end

    // Stage-0 payload: control-flow resolution, mispredict and passthrough fields.
    always_comb begin
        w_stage0         = '0;
        w_stage0.value   = w_alu_res;
        w_stage0.rd      = rd_arch;
        w_stage0.pd      = pd_phys;
        w_stage0.rob     = rob_idx;
        w_stage0.dest_we = dest_we;
        w_stage0.target  = w_pc4;
        case (ctrl_type)
            CTRL_BRANCH: begin
                w_stage0.is_ctrl = 1'b1;
                w_stage0.taken   = w_cond;
                w_stage0.target  = w_cond ? w_pc_imm : w_pc4;
            end
            CTRL_JAL: begin
                w_stage0.is_ctrl = 1'b1;
                w_stage0.taken   = 1'b1;
                w_stage0.target  = w_pc_imm;
                w_stage0.value   = XLEN'(w_pc4);
            end
            CTRL_JALR: begin
                w_stage0.is_ctrl = 1'b1;
                w_stage0.taken   = 1'b1;
                w_stage0.target  = 32'(w_jalr_sum) & ~32'd1;
                w_stage0.value   = XLEN'(w_pc4);
            end
            default: ;
        endcase
        w_stage0.mispredict = w_stage0.is_ctrl &&
                              ((w_stage0.taken != pred_taken) ||
                               (w_stage0.taken && (w_stage0.target != pred_target)));
    end

    // Stage readiness: a stage can load if it or any later stage has a hole, or the CDB pops.
    always_comb begin
        logic acc;
        acc = resp_ready;
        w_stage_ready[STAGES] = resp_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc = acc || !r_valid[i];
            w_stage_ready[i] = acc;
        end
    end

    // Occupancy count from the registered valid bits only.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight = inflight + 3'(r_valid[i]);
        end
    end

    // Pipeline registers: advance each stage whose downstream can take it; flush clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload array is reset too, so resp_* read as zero out of reset.
            r_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            // NOTE: non-blocking updates let stage i read the old stage i-1 in the same edge.
            if (w_stage_ready[0]) begin
                r_valid[0] <= req_valid;
                r_stage[0] <= w_stage0;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_stage_ready[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end
    end

    assign req_ready       = w_stage_ready[0] && !flush;
    assign resp_valid      = r_valid[STAGES-1] && !flush;
    assign resp_value      = r_stage[STAGES-1].value;
    assign resp_rd         = r_stage[STAGES-1].rd;
    assign resp_pd         = r_stage[STAGES-1].pd;
    assign resp_rob_idx    = r_stage[STAGES-1].rob;
    assign resp_dest_we    = r_stage[STAGES-1].dest_we;
    assign resp_is_ctrl    = r_stage[STAGES-1].is_ctrl;
    assign resp_br_taken   = r_stage[STAGES-1].taken;
    assign resp_br_target  = r_stage[STAGES-1].target;
    assign resp_mispredict = r_stage[STAGES-1].mispredict;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU/branch functional unit. It sits between the ALU reservation station and the CDB arbiter. Every accepted op is computed, then carried through `STAGES` register stages with per-stage valid/ready backpressure. Branches are resolved against the front-end prediction to produce a mispredict flag, and a global flush squashes all in-flight ops.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `STAGES`, 2: pipeline depth, legal range 1..4; this is the latency in cycles.
- `ROB_W`, 5: ROB index width.
- `PHYS_W`, 6: physical register index width.
- `ARCH_W`, 5: architectural register index width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req_valid`  in  1: RS issues an op.
- `req_ready`  out  1: unit accepts the op this cycle.
- `op_a`, `op_b`, `op_imm`  in  XLEN each: source operands and immediate.
- `use_imm`  in  1: second ALU operand is `op_imm` instead of `op_b`.
- `alu_op`  in  4: operation select.
- `ctrl_type`  in  2: 0 none, 1 branch, 2 jal, 3 jalr.
- `funct3`  in  3: branch condition.
- `pc`  in  32: pc of the op.
- `pred_taken`  in  1: front-end prediction, taken or not.
- `pred_target`  in  32: front-end predicted target.
- `rd_arch`  in  ARCH_W: destination architectural register, passed through.
- `pd_phys`  in  PHYS_W: destination physical register, passed through.
- `rob_idx`  in  ROB_W: ROB index, passed through.
- `dest_we`  in  1: destination write enable, passed through.
- `flush`  in  1: squash every op in flight.
- `resp_valid`  out  1: result is presented to the CDB.
- `resp_ready`  in  1: CDB accepts the result.
- `resp_value`  out  XLEN: ALU result.
- `resp_rd`, `resp_pd`, `resp_rob_idx`, `resp_dest_we`  out: passthrough fields.
- `resp_is_ctrl`  out  1: op was a branch, jal or jalr.
- `resp_br_taken`  out  1: resolved taken/not-taken.
- `resp_br_target`  out  32: resolved next pc.
- `resp_mispredict`  out  1: resolution disagrees with the prediction.
- `inflight`  out  3: number of valid stages, 0..STAGES.

## Operation
- Op decode:
  - `alu_op`: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU.
  - Values 10–15 give a result of 0.
  - `b = use_imm ? op_imm : op_b`.
  - Shift amount is `b[4:0]` (`$clog2(XLEN)` LSBs).
  - SUB with `use_imm` is still a subtract; decode never generates it.
- Branch (`ctrl_type`=1):
  - `cond` comes from `funct3` compares of `op_a` and `op_b`: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; other values give 0.
  - taken = `cond`; target = taken ? `pc+op_imm` : `pc+4`.
- JAL: taken=1, target=`pc+op_imm`, value=`pc+4`.
- JALR: taken=1, target=`(op_a+op_imm)&~1`, value=`pc+4`.
- Non-ctrl ops: taken=0, target=`pc+4`.
- Mispredict, for ctrl ops only; 0 for non-ctrl ops:
  - `taken != pred_taken`, or
  - `taken && target != pred_target`.
- All arithmetic is modulo 2^XLEN; `pc` arithmetic is modulo 2^32.
- Stage 0 computes all of the above combinationally from the request and registers it into stage register 0. Stage k>0 copies stage k-1. The last stage drives all `resp_*` outputs.
- Stage handshake:
  - `stage_ready[i] = !valid[i] || stage_ready[i+1]`, with `stage_ready[STAGES] = resp_ready`.
  - `req_ready = stage_ready[0] && !flush`.
  - Bubbles collapse: a stalled output never blocks an empty earlier stage.
- Flush:
  - The next edge clears every valid bit.
  - The request presented in the flush cycle is not accepted.
  - `resp_valid` is gated low while `flush` is high, so no result is accepted on the flush cycle.
- `inflight` = popcount of the stage valid bits, registered-state only.

## Timing
- Reset (async, `rst_n` low): all valid bits 0 and all stage payload registers 0. As a result:
  - `resp_valid`=0, `req_ready`=1, `inflight`=0.
  - All `resp_*` = 0, including `resp_br_target`.
- Latency: accepted at edge T, `resp_valid`=1 after edge T+STAGES-1 (cycle T+STAGES-1), given no stalls. STAGES=1 gives a one-cycle unit.
- Throughput: one op per cycle when `resp_ready` is held 1.
- Hold rule: while `resp_valid && !resp_ready`, every `resp_*` field stays stable. Earlier stages fill until full, then `req_ready`=0.
- Simultaneous pop and push on a full pipe: each stage advances with no bubble inserted.
- Reset asserted mid-stall: immediate clear, with no result emitted.
- `flush` and `resp_ready` high in the same cycle: no handshake occurs and the op is dropped.

## Test plan
- Case 1, basic latency:
  - Stimulus: STAGES=2, ADD `op_a`=5, `op_b`=7, `rob_idx`=3.
  - Required: `resp_valid` 2 cycles after accept, value 12, `resp_rob_idx`=3, `resp_is_ctrl`=0.
- Case 2, backpressure:
  - Stimulus: 4 back-to-back SUBs with `resp_ready`=0.
  - Required: `req_ready` drops after STAGES accepts, `inflight`=STAGES, first result held stable.
  - Then raise `resp_ready`: results come out in order, one per cycle.
- Case 3, branch and JALR resolution:
  - Stimulus: BLT `op_a`=0xFFFFFFFF, `op_b`=1, `pc`=0x100, `op_imm`=0x20, `pred_taken`=0.
  - Required: taken=1, target=0x120, `resp_mispredict`=1.
  - Stimulus: JALR `op_a`=0x203, `op_imm`=0, `pred_target`=0x202, `pred_taken`=1.
  - Required: `resp_mispredict`=0, value=`pc+4`.
- Case 4, immediate select:
  - Stimulus: SRL `op_a`=0x80000000, `use_imm`=1, `op_imm`=0 (shift by 0).
  - Required: 0x80000000; `use_imm`=0 with `op_b`=4 gives 0x08000000.
  - Stimulus: SRA with `op_imm`=31.
  - Required: 0xFFFFFFFF.
- Case 5, flush:
  - Stimulus: pipe full and stalled, then `flush` for 1 cycle with `req_valid`=1.
  - Required: `req_ready`=0 in that cycle; next cycle `inflight`=0 and `resp_valid`=0; no op is ever delivered.
- Case 6, async reset:
  - Stimulus: assert `rst_n` low between clock edges with ops in flight.
  - Required: `resp_valid` and `inflight` go to 0 immediately; after release, the first op has full latency.
